// File: rtl/i2c_dac_responder.sv
// I2C target emulating a 2-channel 12-bit DAC register file (write, commit, read-back).
// SCL is observe-only; SDA is open-drain through sda_o.

module i2c_dac_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    logic [1:0] sync;
    logic [2:0] cnt;

    // A new level is accepted only after FILTER_LEN consecutive synced samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == 3'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 3'd1;
            end
        end
    end
endmodule

module i2c_dac_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h60,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic [11:0] dac0_value,
    output logic [11:0] dac1_value,
    output logic        update_stb,
    output logic        update_ch,
    output logic        err_stb,
    output logic        bus_busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WR_HI, WR_HI_ACK, WR_LO, WR_LO_ACK,
        RD_HI, RD_HI_MACK, RD_LO, RD_LO_MACK, IGNORE
    } state_t;

    logic [1:0] raw_lines, flt_lines;
    assign raw_lines = {sda_i, scl_i};

    for (genvar g = 0; g < 2; g++) begin : g_filt
        i2c_dac_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_lines[g]),
            .level(flt_lines[g])
        );
    end

    logic scl_f, sda_f, scl_q, sda_q;
    assign scl_f = flt_lines[0];
    assign sda_f = flt_lines[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [3:0]  hi_nib;
    logic        ptr, rd_req, cmd_rd, ack_ph, mack;
    logic [7:0]  txsh, snap_lo;

    logic [7:0]  nbyte;
    logic        byte_end, commit;
    logic [11:0] cur;
    assign nbyte    = {shreg, sda_f};
    assign byte_end = scl_rise && (bit_cnt == 4'd7);
    assign commit   = (state == WR_LO) && byte_end;
    assign cur      = ptr ? dac1_value : dac0_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            hi_nib   <= '0;
            ptr      <= 1'b0;
            rd_req   <= 1'b0;
            cmd_rd   <= 1'b0;
            ack_ph   <= 1'b0;
            mack     <= 1'b0;
            txsh     <= '0;
            snap_lo  <= '0;
            sda_o    <= 1'b1;
            err_stb  <= 1'b0;
            bus_busy <= 1'b0;
        end else begin
            err_stb <= 1'b0;
            if (start_c) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                ack_ph   <= 1'b0;
                sda_o    <= 1'b1;
                bus_busy <= 1'b1;
            end else if (stop_c) begin
                state    <= IDLE;
                sda_o    <= 1'b1;
                bus_busy <= 1'b0;
            end else begin
                case (state)
                    ADDR, CMD, WR_HI, WR_LO: begin
                        if (scl_rise) begin
                            shreg   <= nbyte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (byte_end) begin
                                bit_cnt <= '0;
                                ack_ph  <= 1'b0;
                                case (state)
                                    ADDR: begin
                                        if (nbyte[7:1] != DEV_ADDR) begin
                                            state <= IGNORE;
                                        end else begin
                                            rd_req <= nbyte[0];
                                            state  <= ADDR_ACK;
                                        end
                                    end
                                    CMD: begin
                                        // Only registers 0/1 with write (00) or read-select (11) are valid.
                                        if (nbyte[7:4] == 4'd0 && nbyte[2] == nbyte[1]) begin
                                            ptr    <= nbyte[3];
                                            cmd_rd <= nbyte[2];
                                            state  <= CMD_ACK;
                                        end else begin
                                            err_stb <= 1'b1;
                                            state   <= IGNORE;
                                        end
                                    end
                                    WR_HI: begin
                                        hi_nib <= nbyte[3:0];
                                        state  <= WR_HI_ACK;
                                    end
                                    default: state <= WR_LO_ACK;
                                endcase
                            end
                        end
                    end
                    ADDR_ACK, CMD_ACK, WR_HI_ACK, WR_LO_ACK: begin
                        if (scl_fall) begin
                            if (!ack_ph) begin
                                sda_o  <= 1'b0;
                                ack_ph <= 1'b1;
                            end else begin
                                ack_ph  <= 1'b0;
                                bit_cnt <= '0;
                                sda_o   <= 1'b1;
                                case (state)
                                    ADDR_ACK: begin
                                        if (rd_req) begin
                                            state   <= RD_HI;
                                            txsh    <= {4'd0, cur[11:8]};
                                            snap_lo <= cur[7:0];
                                            sda_o   <= 1'b0;
                                        end else begin
                                            state <= CMD;
                                        end
                                    end
                                    CMD_ACK:   state <= cmd_rd ? IGNORE : WR_HI;
                                    WR_HI_ACK: state <= WR_LO;
                                    default:   state <= CMD;
                                endcase
                            end
                        end
                    end
                    RD_HI, RD_LO: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_o   <= 1'b1;
                                bit_cnt <= '0;
                                state   <= (state == RD_HI) ? RD_HI_MACK : RD_LO_MACK;
                            end else begin
                                sda_o <= txsh[6];
                                txsh  <= {txsh[6:0], 1'b0};
                            end
                        end
                    end
                    RD_HI_MACK, RD_LO_MACK: begin
                        if (scl_rise) mack <= ~sda_f;
                        if (scl_fall) begin
                            if (!mack) begin
                                state <= IGNORE;
                                sda_o <= 1'b1;
                            end else if (state == RD_HI_MACK) begin
                                state <= RD_LO;
                                txsh  <= snap_lo;
                                sda_o <= snap_lo[7];
                            end else begin
                                state   <= RD_HI;
                                txsh    <= {4'd0, cur[11:8]};
                                snap_lo <= cur[7:0];
                                sda_o   <= 1'b0;
                            end
                        end
                    end
                    IGNORE:  sda_o <= 1'b1;
                    default: sda_o <= 1'b1;
                endcase
            end
        end
    end

    // Commit path sits outside the START/STOP priority so a completed low byte always lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac0_value <= '0;
            dac1_value <= '0;
            update_stb <= 1'b0;
            update_ch  <= 1'b0;
        end else begin
            update_stb <= 1'b0;
            if (commit) begin
                if (ptr) dac1_value <= {hi_nib, nbyte};
                else     dac0_value <= {hi_nib, nbyte};
                update_stb <= 1'b1;
                update_ch  <= ptr;
            end
        end
    end
endmodule

// File: tb/tb_i2c_dac_responder.sv
// Directed bench for i2c_dac_responder: a bit-banged I2C master with wired-AND SDA.

module tb_i2c_dac_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_m, sda_m;
    logic        sda_o;
    logic [11:0] dac0_value, dac1_value;
    logic        update_stb, update_ch, err_stb, bus_busy;
    logic        sda_line;

    assign sda_line = sda_m & sda_o;

    i2c_dac_responder #(.DEV_ADDR(7'h60), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .dac0_value(dac0_value),
        .dac1_value(dac1_value),
        .update_stb(update_stb),
        .update_ch (update_ch),
        .err_stb   (err_stb),
        .bus_busy  (bus_busy)
    );

    always #5 clk = ~clk;

    int       n_chk = 0, n_pass = 0;
    int       stb_cnt = 0, err_cnt = 0, low_cnt = 0;
    logic [1:0] ch_hist = 2'b00;

    always @(negedge clk) begin
        if (update_stb) begin
            stb_cnt <= stb_cnt + 1;
            ch_hist <= {ch_hist[0], update_ch};
        end
        if (err_stb) err_cnt <= err_cnt + 1;
        if (!sda_o)  low_cnt <= low_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic hw();
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; hw();
        scl_m = 1'b1; hw();
        sda_m = 1'b0; hw();
        scl_m = 1'b0; hw();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hw();
        scl_m = 1'b1; hw();
        sda_m = 1'b1; hw();
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit glitch, input bit rst_ack, output bit ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; hw();
            scl_m = 1'b1; hw();
            scl_m = 1'b0; hw();
            if (glitch && i == 4) begin
                scl_m = 1'b1;
                repeat (2) @(negedge clk);
                scl_m = 1'b0;
                hw();
            end
        end
        sda_m = 1'b1; hw();
        scl_m = 1'b1; hw();
        ack = !sda_line;
        if (rst_ack) begin
            chk("rst_pre_ack_low", {31'd0, sda_o}, 32'd0);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_sda_o", {31'd0, sda_o}, 32'd1);
            chk("rst_dac0", {20'd0, dac0_value}, 32'd0);
            chk("rst_dac1", {20'd0, dac1_value}, 32'd0);
            chk("rst_busy", {31'd0, bus_busy}, 32'd0);
            hw();
            rst_n = 1'b1;
            hw();
        end
        scl_m = 1'b0; hw();
    endtask

    task automatic rd_byte(input bit mack, output logic [7:0] b);
        sda_m = 1'b1;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            hw();
            scl_m = 1'b1; hw();
            b = {b[6:0], sda_line};
            scl_m = 1'b0;
        end
        hw();
        sda_m = !mack; hw();
        scl_m = 1'b1;  hw();
        scl_m = 1'b0;  hw();
        sda_m = 1'b1;
    endtask

    task automatic wr_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        bit a;
        i2c_start();
        wr_byte(b0, 0, 0, a);
        wr_byte(b1, 0, 0, a);
        wr_byte(b2, 0, 0, a);
        wr_byte(b3, 0, 0, a);
        i2c_stop();
    endtask

    initial begin
        bit         ak [0:7];
        int         s0, l0, e0;
        logic [7:0] rb0, rb1;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_async_sda", {31'd0, sda_o}, 32'd1);
        rst_n = 1'b1;
        hw();
        chk("init_sda_o",  {31'd0, sda_o}, 32'd1);
        chk("init_dac0",   {20'd0, dac0_value}, 32'd0);
        chk("init_dac1",   {20'd0, dac1_value}, 32'd0);
        chk("init_stb",    {31'd0, update_stb}, 32'd0);
        chk("init_ch",     {31'd0, update_ch}, 32'd0);
        chk("init_err",    {31'd0, err_stb}, 32'd0);
        chk("init_busy",   {31'd0, bus_busy}, 32'd0);

        // 1: write 0xABC to channel 1
        s0 = stb_cnt;
        i2c_start();
        chk("t1_busy_start", {31'd0, bus_busy}, 32'd1);
        wr_byte(8'hC0, 0, 0, ak[0]);
        wr_byte(8'h08, 0, 0, ak[1]);
        wr_byte(8'h0A, 0, 0, ak[2]);
        wr_byte(8'hBC, 0, 0, ak[3]);
        chk("t1_acks", {28'd0, ak[0], ak[1], ak[2], ak[3]}, 32'hF);
        i2c_stop();
        chk("t1_dac1", {20'd0, dac1_value}, 32'hABC);
        chk("t1_dac0", {20'd0, dac0_value}, 32'h000);
        chk("t1_stb_cnt", stb_cnt - s0, 32'd1);
        chk("t1_ch", {31'd0, update_ch}, 32'd1);
        chk("t1_busy_stop", {31'd0, bus_busy}, 32'd0);

        // 2: wrong address is ignored entirely
        s0 = stb_cnt; l0 = low_cnt;
        i2c_start();
        wr_byte(8'hC2, 0, 0, ak[0]);
        wr_byte(8'h08, 0, 0, ak[1]);
        wr_byte(8'h01, 0, 0, ak[2]);
        wr_byte(8'h23, 0, 0, ak[3]);
        chk("t2_acks", {28'd0, ak[0], ak[1], ak[2], ak[3]}, 32'h0);
        chk("t2_busy", {31'd0, bus_busy}, 32'd1);
        i2c_stop();
        chk("t2_busy_stop", {31'd0, bus_busy}, 32'd0);
        chk("t2_sda_low", low_cnt - l0, 32'd0);
        chk("t2_stb_cnt", stb_cnt - s0, 32'd0);
        chk("t2_dac1", {20'd0, dac1_value}, 32'hABC);

        // 3: continuous write of both channels
        s0 = stb_cnt;
        i2c_start();
        wr_byte(8'hC0, 0, 0, ak[0]);
        wr_byte(8'h00, 0, 0, ak[1]);
        wr_byte(8'h01, 0, 0, ak[2]);
        wr_byte(8'h23, 0, 0, ak[3]);
        wr_byte(8'h08, 0, 0, ak[4]);
        wr_byte(8'h04, 0, 0, ak[5]);
        wr_byte(8'h56, 0, 0, ak[6]);
        i2c_stop();
        chk("t3_acks", {25'd0, ak[0], ak[1], ak[2], ak[3], ak[4], ak[5], ak[6]}, 32'h7F);
        chk("t3_dac0", {20'd0, dac0_value}, 32'h123);
        chk("t3_dac1", {20'd0, dac1_value}, 32'h456);
        chk("t3_stb_cnt", stb_cnt - s0, 32'd2);
        chk("t3_ch_order", {30'd0, ch_hist}, 32'b01);

        // 4: read-back of channel 1 after read-select command
        wr_seq(8'hC0, 8'h08, 8'h0A, 8'hBC);
        chk("t4_pre_dac1", {20'd0, dac1_value}, 32'hABC);
        i2c_start();
        wr_byte(8'hC0, 0, 0, ak[0]);
        wr_byte(8'h0E, 0, 0, ak[1]);
        i2c_start();
        wr_byte(8'hC1, 0, 0, ak[2]);
        chk("t4_acks", {29'd0, ak[0], ak[1], ak[2]}, 32'h7);
        rd_byte(1, rb0);
        rd_byte(0, rb1);
        chk("t4_rd_hi", {24'd0, rb0}, 32'h0A);
        chk("t4_rd_lo", {24'd0, rb1}, 32'hBC);
        chk("t4_sda_rel", {31'd0, sda_o}, 32'd1);
        i2c_stop();

        // 5: invalid command, then partial write
        s0 = stb_cnt; e0 = err_cnt;
        i2c_start();
        wr_byte(8'hC0, 0, 0, ak[0]);
        wr_byte(8'h10, 0, 0, ak[1]);
        wr_byte(8'h01, 0, 0, ak[2]);
        i2c_stop();
        chk("t5_acks", {29'd0, ak[0], ak[1], ak[2]}, 32'h4);
        chk("t5_err_cnt", err_cnt - e0, 32'd1);
        i2c_start();
        wr_byte(8'hC0, 0, 0, ak[0]);
        wr_byte(8'h00, 0, 0, ak[1]);
        wr_byte(8'h0F, 0, 0, ak[2]);
        i2c_stop();
        chk("t5_part_acks", {29'd0, ak[0], ak[1], ak[2]}, 32'h7);
        chk("t5_stb_cnt", stb_cnt - s0, 32'd0);
        chk("t5_dac0", {20'd0, dac0_value}, 32'h123);

        // 6: sub-threshold SCL glitch, then reset mid-ACK
        s0 = stb_cnt;
        i2c_start();
        wr_byte(8'hC0, 0, 0, ak[0]);
        wr_byte(8'h00, 0, 0, ak[1]);
        wr_byte(8'h07, 1, 0, ak[2]);
        wr_byte(8'h89, 0, 0, ak[3]);
        i2c_stop();
        chk("t6_acks", {28'd0, ak[0], ak[1], ak[2], ak[3]}, 32'hF);
        chk("t6_dac0", {20'd0, dac0_value}, 32'h789);
        chk("t6_stb_cnt", stb_cnt - s0, 32'd1);
        i2c_start();
        wr_byte(8'hC0, 0, 1, ak[0]);
        i2c_stop();
        chk("t6_post_dac0", {20'd0, dac0_value}, 32'd0);
        chk("t6_post_busy", {31'd0, bus_busy}, 32'd0);
        chk("t6_post_sda", {31'd0, sda_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
